// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encodings,
// default widths and the starvation-counter width helper.
package dmem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_STARVE_MAX = 8;

  // Port ownership states
  localparam logic [1:0] ST_CORE_OWN  = 2'd0;
  localparam logic [1:0] ST_EXT_FORCE = 2'd1;
  localparam logic [1:0] ST_EXT_LOCK  = 2'd2;

  // Counter must be able to hold the value max itself
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive denied external cycles.
// hit flags the cycle in which an increment reaches (or sits at) the limit.
module starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = DEF_STARVE_MAX,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [W-1:0] LIMIT = W'(MAX);
  localparam logic [W-1:0] LAST  = W'(MAX - 1);

  logic [W-1:0] count;

  // An increment from LAST lands on LIMIT; a saturated counter keeps hitting
  assign hit = inc & ((count == LAST) | (count == LIMIT));

  // Count denied cycles, clearing on service or withdrawal, saturating at LIMIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single Data_Memory port between the single-cycle core and one
// external master. The core has priority; a starvation counter forces an
// external grant, and a lock mode lets the external master hold the port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  // core load/store side
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  // external master side
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  // Data_Memory port
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       core_drives;
  logic       ext_read_accept;
  logic       starve_inc;
  logic       starve_clr;
  logic       starve_hit;

  // Same-cycle grant decision; all handshake outputs held low during reset
  always_comb begin
    ext_ready   = 1'b0;
    core_stall  = 1'b0;
    core_drives = 1'b0;
    if (rst) begin
      case (state)
        ST_EXT_FORCE: begin
          ext_ready  = ext_valid;
          core_stall = core_req;
        end
        ST_EXT_LOCK: begin
          ext_ready  = ext_valid;
          core_stall = 1'b1;
        end
        default: begin
          core_drives = core_req;
          ext_ready   = ext_valid & ~core_req;
        end
      endcase
    end
  end

  // Memory port mux; a write strobe only ever follows a granted requester
  always_comb begin
    if (core_drives) begin
      mem_a  = core_addr;
      mem_wd = core_wdata;
      mem_we = core_we;
    end else begin
      mem_a  = ext_addr;
      mem_wd = ext_wdata;
      mem_we = ext_ready & ext_we;
    end
  end

  assign core_rdata      = mem_rd;
  assign ext_read_accept = ext_ready & ~ext_we;

  assign starve_inc = ext_valid & ~ext_ready;
  assign starve_clr = ~ext_valid | ext_ready;

  starve_counter #(
    .MAX (STARVE_MAX),
    .W   (cnt_width(STARVE_MAX))
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .hit (starve_hit)
  );

  // Next-state: a locked acceptance wins from any state, else per-state exit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CORE_OWN:  if (starve_hit) state_nxt = ST_EXT_FORCE;
      ST_EXT_FORCE: state_nxt = ST_CORE_OWN;
      ST_EXT_LOCK:  if (!ext_lock) state_nxt = ST_CORE_OWN;
      default:      state_nxt = ST_CORE_OWN;
    endcase
    if (ext_ready && ext_lock) begin
      state_nxt = ST_EXT_LOCK;
    end
  end

  // Ownership state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_CORE_OWN;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered read response; data holds until the next accepted read
  always_ff @(posedge clk) begin
    if (!rst) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_read_accept;
      if (ext_read_accept) begin
        ext_rdata <= mem_rd;
      end
    end
  end

  // A stalled core must never see its store reach memory
  a_no_stalled_store: assert property (@(posedge clk) core_stall |-> !core_drives);
  // No write strobe while reset is asserted
  a_no_we_in_reset: assert property (@(posedge clk) !rst |-> !mem_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural Data_Memory.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and checks.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_valid, ext_ready, ext_we, ext_lock, ext_rvalid;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];

  typedef struct {
    string       nm;
    bit          ready;
    bit          stall;
    bit          we;
    bit          rv;
    bit          chk_rd;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .ext_valid  (ext_valid),
    .ext_ready  (ext_ready),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_lock   (ext_lock),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Data_Memory: combinational read, write at the clock edge
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, want);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".ext_ready"},  {31'd0, ext_ready},  {31'd0, e.ready});
      chk({e.nm, ".core_stall"}, {31'd0, core_stall}, {31'd0, e.stall});
      chk({e.nm, ".mem_we"},     {31'd0, mem_we},     {31'd0, e.we});
      chk({e.nm, ".ext_rvalid"}, {31'd0, ext_rvalid}, {31'd0, e.rv});
      if (e.chk_rd) chk({e.nm, ".ext_rdata"}, ext_rdata, e.rd);
      if (e.we) begin
        chk({e.nm, ".mem_a"},  mem_a,  e.a);
        chk({e.nm, ".mem_wd"}, mem_wd, e.wd);
      end
    end
  end

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic ev, input logic ewe,
                       input logic [31:0] eaddr, input logic [31:0] ewd, input logic elk);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    ext_valid = ev; ext_we = ewe; ext_addr = eaddr; ext_wdata = ewd; ext_lock = elk;
  endtask

  // Push this cycle's expectation, then advance to just after the next edge
  task automatic cyc(input string nm, input bit r, input bit s, input bit w, input bit v,
                     input bit crd, input logic [31:0] rd,
                     input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.nm = nm; e.ready = r; e.stall = s; e.we = w; e.rv = v;
    e.chk_rd = crd; e.rd = rd; e.a = a; e.wd = wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b0;
    drive(1, 1, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;

    // Reset: everything forced low, response register cleared
    cyc("reset", 0, 0, 0, 0, 1, 32'h0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle0", 0, 0, 0, 0, 0, 0, 0, 0);

    // Idle core: external write then read of 0x40
    drive(0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0);
    cyc("idle_wr", 1, 0, 1, 0, 0, 0, 32'h40, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 1, 0, 32'h40, 32'h0, 0);
    cyc("idle_rd", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle_resp", 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0);
    cyc("idle_hold", 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);

    // Contention: core stores to 0x10 while external writes 0x10
    drive(1, 1, 32'h10, 32'h11111111, 1, 1, 32'h10, 32'h22222222, 0);
    for (int i = 0; i < 8; i++) cyc("cont_deny", 0, 0, 1, 0, 0, 0, 32'h10, 32'h11111111);
    cyc("cont_force", 1, 1, 1, 0, 0, 0, 32'h10, 32'h22222222);
    drive(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
    cyc("cont_resume", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
    cyc("cont_rd", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("cont_resp", 0, 0, 0, 1, 1, 32'h22222222, 0, 0);

    // Lock burst entered from a forced grant, lock dropped on the 4th write
    drive(1, 0, 32'h80, 0, 1, 1, 32'h20, 32'hA0, 1);
    for (int i = 0; i < 8; i++) cyc("lock_deny", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("lock_w0", 1, 1, 1, 0, 0, 0, 32'h20, 32'hA0);
    drive(1, 0, 32'h80, 0, 1, 1, 32'h24, 32'hA1, 1);
    cyc("lock_w1", 1, 1, 1, 0, 0, 0, 32'h24, 32'hA1);
    drive(1, 0, 32'h80, 0, 1, 1, 32'h28, 32'hA2, 1);
    cyc("lock_w2", 1, 1, 1, 0, 0, 0, 32'h28, 32'hA2);
    drive(1, 0, 32'h80, 0, 1, 1, 32'h2C, 32'hA3, 0);
    cyc("lock_w3", 1, 1, 1, 0, 0, 0, 32'h2C, 32'hA3);
    drive(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
    cyc("lock_exit", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a lock
    drive(0, 0, 0, 0, 1, 1, 32'h30, 32'hB0, 1);
    cyc("rlock_w0", 1, 0, 1, 0, 0, 0, 32'h30, 32'hB0);
    drive(0, 0, 0, 0, 1, 1, 32'h34, 32'hB1, 1);
    cyc("rlock_w1", 1, 1, 1, 0, 0, 0, 32'h34, 32'hB1);
    rst = 1'b0;
    drive(1, 1, 32'h3C, 32'hC0, 1, 0, 32'h20, 0, 1);
    cyc("rlock_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(1, 1, 32'h3C, 32'hC0, 1, 1, 32'h38, 32'hEE, 0);
    cyc("rlock_after", 0, 0, 1, 0, 1, 32'h0, 32'h3C, 32'hC0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rlock_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // External valid dropped in the forced cycle, then a full new wait
    drive(1, 0, 32'h80, 0, 1, 1, 32'h50, 32'h55, 0);
    for (int i = 0; i < 8; i++) cyc("drop_deny", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("drop_force", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h80, 0, 1, 1, 32'h50, 32'h56, 0);
    for (int i = 0; i < 8; i++) cyc("redo_deny", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("redo_force", 1, 1, 1, 0, 0, 0, 32'h50, 32'h56);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("final_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);

    // Final memory image
    chk("mem_10", mem[32'h10 >> 2], 32'h22222222);
    chk("mem_20", mem[32'h20 >> 2], 32'hA0);
    chk("mem_24", mem[32'h24 >> 2], 32'hA1);
    chk("mem_28", mem[32'h28 >> 2], 32'hA2);
    chk("mem_2C", mem[32'h2C >> 2], 32'hA3);
    chk("mem_30", mem[32'h30 >> 2], 32'hB0);
    chk("mem_34", mem[32'h34 >> 2], 32'hB1);
    chk("mem_38", mem[32'h38 >> 2], 32'h0);
    chk("mem_3C", mem[32'h3C >> 2], 32'hC0);
    chk("mem_40", mem[32'h40 >> 2], 32'hDEADBEEF);
    chk("mem_50", mem[32'h50 >> 2], 32'h56);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single Data_Memory port between the RISC-V single-cycle core and one external bus master (program loader / debug port). It sits between the core's load/store signals and Data_Memory in the top level. The core has priority, and a bounded-starvation counter guarantees the external master progress. The core is stalled through `core_stall` whenever it loses the port. A lock mode lets the external master own memory for a burst.

## Interface
Parameters:
- `ADDR_W`, 32, address width passed to Data_Memory
- `DATA_W`, 32, data width
- `STARVE_MAX`, 8, consecutive denied external cycles before a forced grant (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low reset
- `core_req` in 1: core performs a load or store this cycle
- `core_we` in 1: core store (1) / load (0)
- `core_addr` in ADDR_W: core address (ALUResult)
- `core_wdata` in DATA_W: core store data (RD2)
- `core_rdata` out DATA_W: read data to core; equals `mem_rd`
- `core_stall` out 1: core must hold PC and suppress RegWrite this cycle
- `ext_valid` in 1: external request valid
- `ext_ready` out 1: external request accepted this cycle
- `ext_we` in 1: external write (1) / read (0)
- `ext_addr` in ADDR_W, `ext_wdata` in DATA_W: external address and data
- `ext_lock` in 1: keep ownership after the current accepted transfer
- `ext_rvalid` out 1: registered read response pulse
- `ext_rdata` out DATA_W: registered read data
- `mem_we` out 1, `mem_a` out ADDR_W, `mem_wd` out DATA_W: to Data_Memory WE/A/WD
- `mem_rd` in DATA_W: from Data_Memory RD (combinational read)

## Operation
- States: CORE_OWN (reset), EXT_FORCE, EXT_LOCK.
- CORE_OWN:
  - `ext_ready = ext_valid & ~core_req`; `core_stall = 0`.
  - The port drives core signals when `core_req`, else external signals.
- EXT_FORCE:
  - `ext_ready = ext_valid`; `core_stall = core_req`.
  - The port drives external signals.
  - Always returns to CORE_OWN next cycle, unless the transfer is accepted with `ext_lock=1` (→ EXT_LOCK).
- EXT_LOCK:
  - `ext_ready = ext_valid`; `core_stall = 1` unconditionally.
  - The port drives external signals; `mem_we = ext_valid & ext_we`.
  - Exits to CORE_OWN in the first cycle `ext_lock=0` is sampled; that cycle still serves any external request.
- Entry to EXT_LOCK: from any state, when an external transfer is accepted with `ext_lock=1`.
- `mem_we` is `core_req & core_we` when the core drives the port, `ext_ready & ext_we` when the external master drives it, and 0 otherwise. It is never 1 for a stalled or unaccepted requester.
- Starvation counter (width `$clog2(STARVE_MAX+1)`):
  - Increments each cycle with `ext_valid & ~ext_ready`.
  - Clears on an accepted transfer or when `ext_valid=0`.
  - Saturates at `STARVE_MAX`.
  - When the increment reaches `STARVE_MAX`, the next state is EXT_FORCE.
- Handshake rule: once `ext_valid` rises, the master holds `ext_valid`, `ext_we`, `ext_addr` and `ext_wdata` stable until `ext_ready`.
  - If `ext_valid` drops anyway in EXT_FORCE, no transfer occurs, the counter clears and the state returns to CORE_OWN.
- Read response: an accepted read (`ext_we=0`) captures `mem_rd` into `ext_rdata`, and `ext_rvalid` pulses the next cycle.
  - `ext_rdata` holds until the next accepted read.
  - Writes produce no response.
- The stalled core re-presents the same instruction; no core request is lost or duplicated.

## Timing
- Reset (`rst=0` at an edge): state CORE_OWN, counter 0, `ext_rvalid=0`, `ext_rdata=0`.
- While `rst=0`, combinational outputs are forced: `ext_ready=0`, `core_stall=0`, `mem_we=0`.
- Reset mid-lock or mid-force returns to CORE_OWN at that edge; no write is issued in that cycle.
- The grant decision is combinational in the same cycle; external write latency is 0 (committed at the accepting edge).
- External read latency: 1 cycle (`ext_rvalid` on the cycle after acceptance).
- Worst-case external wait with a continuously busy core: `STARVE_MAX` denied cycles, then a grant in the next cycle.
- With `STARVE_MAX=1`, the core and external master alternate under full contention.

## Structure
- A shared package/header holds the state encodings `ST_CORE_OWN=2'd0`, `ST_EXT_FORCE=2'd1`, `ST_EXT_LOCK=2'd2` and the default widths.
- One sub-module, `starve_counter`: saturating counter with inc/clear inputs and a `hit` output.
- The FSM, port mux and response register stay in `dmem_arbiter`.

## Test plan
- **Idle core:** `core_req=0`, external write 0xDEADBEEF to 0x40, then a read of 0x40 → `ext_ready` in the same cycle; `ext_rvalid=1` and `ext_rdata=0xDEADBEEF` one cycle after the read is accepted.
- **Contention:** `core_req=1` continuously, `ext_valid=1`, `STARVE_MAX=8` → 8 denied cycles, then `ext_ready=1` and `core_stall=1` for exactly 1 cycle, then the core resumes.
- **Simultaneous core store and external write to 0x10:** the core's data lands first; the external write lands in the forced cycle, and memory ends with the external value.
- **Lock burst:** `ext_lock=1` over 4 writes, with `ext_lock` dropped on the 4th → `core_stall=1` for all 4 cycles, CORE_OWN on the next cycle, all 4 words written.
- **Reset mid-lock:** `rst=0` for 1 cycle during EXT_LOCK → `core_stall=0`, `ext_rvalid=0`, `mem_we=0` during reset; CORE_OWN afterwards.
- **Dropped valid in EXT_FORCE:** `ext_valid` falls in the forced cycle → no write, counter 0, no `core_stall`.
